counter_cmd_driver: RTL
=======================

# counter_cmd_driver

Command-driven initiator for the `behav_counter` control interface. It accepts CLEAR / LOAD / UP / DOWN commands over a valid/ready handshake and converts them into cycle-accurate `clear`, `load`, `up_down` and `d` drive. It also keeps a shadow copy of the expected count, compares it against the counter's `qd`, and flags any divergence. The block sits between a test/sequencer host and one `behav_counter` instance.

## Interface
- `WIDTH`, 8: counter data width.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: command accepted on a cycle where `cmd_valid && cmd_ready`.
- `cmd_op` input 2: opcode. 00 CLEAR, 01 LOAD, 10 UP, 11 DOWN.
- `cmd_arg` input WIDTH: load value for LOAD, step count for UP/DOWN, ignored for CLEAR.
- `clear` output 1: counter clear, active-low.
- `load` output 1: counter load, active-high.
- `up_down` output 1: count direction, 1 = up.
- `d` output WIDTH: counter load data.
- `qd` input WIDTH: counter output.
- `done` output 1: one-cycle pulse when a command completes.
- `busy` output 1: high when not in IDLE.
- `mismatch` output 1: sticky flag, `qd` diverged from the shadow.
- `mismatch_cnt` output 8: number of mismatching cycles, saturates at 255.

## Operation
- Counter model, applied per edge in priority order:
  - `clear`=0 gives 0.
  - else `load`=1 gives `d`.
  - else count by ±1 per `up_down`, modulo 2^WIDTH.
- All control outputs are registered.
- FSM states: IDLE, CLEAR, LOAD, RUN.
- IDLE:
  - Outputs `clear`=1, `load`=1, `d` = shadow, so the counter holds its value.
  - `cmd_ready`=1.
  - On accept, go to the state for the opcode.
- CLEAR: `clear`=0 for 1 cycle; shadow becomes 0; return to IDLE with `done`.
- LOAD: `load`=1, `d`=`cmd_arg` for 1 cycle; shadow becomes arg; return to IDLE with `done`.
- RUN:
  - `load`=0, `clear`=1, `up_down` per opcode, for exactly `cmd_arg` cycles.
  - A step counter counts down from arg.
  - Shadow ±1 per cycle, with wrap (0xFF+1 → 0x00, 0x00−1 → 0xFF).
  - Return to IDLE with `done`.
- UP/DOWN with arg=0: no RUN cycles; `done` the cycle after accept.
- `cmd_ready`=0 in every state except IDLE, so there is at least one hold cycle between commands.
- Shadow update:
  - Shadow updates on the same edge at which the counter samples the currently presented outputs.
  - Shadow always equals the expected `qd`.

## Timing
- Reset values:
  - `clear`=0 (the counter is cleared on every edge during reset), `load`=0, `up_down`=0, `d`=0.
  - `done`=0, `busy`=0, `cmd_ready`=0.
  - `mismatch`=0, `mismatch_cnt`=0, shadow=0.
  - State IDLE, checker disarmed.
- First cycle after reset: `cmd_ready`=1. The checker arms on the first edge after reset (at that edge `clear` is still 0).
- Command effect latency:
  - Outputs change 1 cycle after accept.
  - `qd` reflects the command 2 cycles after accept.
- Compare rule: while armed, any cycle with `qd` != shadow sets `mismatch` and increments `mismatch_cnt`.
- Reset asserted mid-command:
  - The command is abandoned with no `done`.
  - Outputs return to reset values on the next edge.
  - Sticky flags clear.
- `cmd_valid` while not ready is ignored. The host must hold it.

## Configuration
- `CNT_DRV_CHECK_EN` defined: shadow comparator, `mismatch` and `mismatch_cnt` are present.
- `CNT_DRV_CHECK_EN` undefined:
  - Comparator logic is removed; `mismatch` and `mismatch_cnt` are tied 0.
  - `qd` is used only to seed nothing (the input is unused).
  - Drive behaviour is identical.

## Structure
- Shared package `counter_pkg` holds:
  - The `cnt_op_e` enum (CLEAR, LOAD, UP, DOWN).
  - The FSM state enum.
  - `MISMATCH_CNT_W` = 8.
- One sub-module: `counter_shadow_check`, holding the shadow register, comparator and saturating mismatch counter. It is instantiated only under `CNT_DRV_CHECK_EN`.

## Test plan
- Reset held 3 cycles → `clear`=0 throughout reset, `cmd_ready`=1 on the first cycle after, `qd`=0x00, `mismatch`=0.
- LOAD 0x5A → `load`=1, `d`=0x5A for 1 cycle, `done` pulse, `qd`=0x5A two cycles after accept and held steady in IDLE.
- From 0xFE, UP 3 → `up_down`=1 for 3 cycles, `qd` goes 0xFF, 0x00, 0x01, `done`, no mismatch.
- From 0x01, DOWN 2 → `qd` goes 0x00, 0xFF; then UP 0 → `done` one cycle after accept, `qd` stays 0xFF.
- From 0x80, CLEAR → `clear`=0 for 1 cycle, `qd`=0x00; force `qd`=0x07 for 2 cycles → `mismatch`=1, `mismatch_cnt`=2 (both 0 when macro undefined).
- UP 10, reset asserted after 4 steps → no `done`, `clear`=0 on the next cycle, `qd`=0x00, flags cleared.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared opcodes, FSM states and constants for the counter command driver
package counter_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } cnt_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_RUN
    } drv_state_e;

    localparam int MISMATCH_CNT_W = 8;

    // Saturating increment for the mismatch counter; sticks at all-ones.
    function automatic logic [MISMATCH_CNT_W-1:0] sat_inc(input logic [MISMATCH_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/counter_shadow_check.sv
// rtl/counter_shadow_check.sv - shadow counter model, qd comparator and saturating mismatch counter
module counter_shadow_check
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_clear,
    input  logic                      i_load,
    input  logic                      i_up_down,
    input  logic [WIDTH-1:0]          i_d,
    input  logic [WIDTH-1:0]          i_qd,
    output logic                      o_mismatch,
    output logic [MISMATCH_CNT_W-1:0] o_mismatch_cnt
);

    logic [WIDTH-1:0]          r_shadow;
    logic [WIDTH-1:0]          w_shadow_next;
    logic                      r_armed;
    logic                      r_mismatch;
    logic [MISMATCH_CNT_W-1:0] r_mismatch_cnt;

    // Value the counter takes at the next edge given the control it is sampling now.
    always_comb begin
        w_shadow_next = r_shadow;
        if (!i_clear) begin
            w_shadow_next = '0;
        end else if (i_load) begin
            w_shadow_next = i_d;
        end else if (i_up_down) begin
            w_shadow_next = r_shadow + 1'b1;
        end else begin
            w_shadow_next = r_shadow - 1'b1;
        end
    end

    // Shadow tracks the counter on the same edge; checker arms on the first edge out of reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shadow <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_shadow <= w_shadow_next;
            r_armed  <= 1'b1;
        end
    end

    // Sticky divergence flag and per-cycle mismatch count while armed.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mismatch     <= 1'b0;
            r_mismatch_cnt <= '0;
        end else if (r_armed && (i_qd != r_shadow)) begin
            r_mismatch     <= 1'b1;
            r_mismatch_cnt <= sat_inc(r_mismatch_cnt);
        end
    end

    assign o_mismatch     = r_mismatch;
    assign o_mismatch_cnt = r_mismatch_cnt;

endmodule

// File: rtl/counter_cmd_driver.sv
// rtl/counter_cmd_driver.sv - command-driven initiator for behav_counter; CNT_DRV_CHECK_EN adds the qd shadow checker
module counter_cmd_driver
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic [1:0]                i_cmd_op,
    input  logic [WIDTH-1:0]          i_cmd_arg,
    output logic                      o_clear,
    output logic                      o_load,
    output logic                      o_up_down,
    output logic [WIDTH-1:0]          o_d,
    input  logic [WIDTH-1:0]          i_qd,
    output logic                      o_done,
    output logic                      o_busy,
    output logic                      o_mismatch,
    output logic [MISMATCH_CNT_W-1:0] o_mismatch_cnt
);

    drv_state_e       r_state;
    logic [WIDTH-1:0] r_steps;
    logic             r_clear;
    logic             r_load;
    logic             r_up_down;
    logic [WIDTH-1:0] r_d;
    logic             r_done;
    logic             r_busy;
    logic             r_cmd_ready;

    cnt_op_e          w_op;
    logic             w_accept;

    assign w_op     = cnt_op_e'(i_cmd_op);
    assign w_accept = i_cmd_valid && r_cmd_ready;

    // Command FSM with registered drive. r_d always carries the expected count outside
    // of a LOAD, so IDLE can hold the counter by reloading it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_steps     <= '0;
            r_clear     <= 1'b0;
            r_load      <= 1'b0;
            r_up_down   <= 1'b0;
            r_d         <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clear     <= 1'b1;
                    r_load      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        // Ready drops for at least one cycle after every accept.
                        r_cmd_ready <= 1'b0;
                        case (w_op)
                            OP_CLEAR: begin
                                r_state <= ST_CLEAR;
                                r_clear <= 1'b0;
                                r_load  <= 1'b0;
                                r_busy  <= 1'b1;
                            end
                            OP_LOAD: begin
                                r_state <= ST_LOAD;
                                r_d     <= i_cmd_arg;
                                r_busy  <= 1'b1;
                            end
                            default: begin
                                if (i_cmd_arg == '0) begin
                                    // Zero-step count: complete immediately, counter keeps holding.
                                    r_done <= 1'b1;
                                end else begin
                                    r_state   <= ST_RUN;
                                    r_load    <= 1'b0;
                                    r_up_down <= (w_op == OP_UP);
                                    r_steps   <= i_cmd_arg;
                                    r_busy    <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_CLEAR: begin
                    r_state     <= ST_IDLE;
                    r_clear     <= 1'b1;
                    r_load      <= 1'b1;
                    r_d         <= '0;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                ST_LOAD: begin
                    r_state     <= ST_IDLE;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                ST_RUN: begin
                    r_d     <= r_up_down ? r_d + 1'b1 : r_d - 1'b1;
                    r_steps <= r_steps - 1'b1;
                    if (r_steps == WIDTH'(1)) begin
                        r_state     <= ST_IDLE;
                        r_load      <= 1'b1;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_clear     = r_clear;
    assign o_load      = r_load;
    assign o_up_down   = r_up_down;
    assign o_d         = r_d;
    assign o_done      = r_done;
    assign o_busy      = r_busy;

`ifdef CNT_DRV_CHECK_EN
    counter_shadow_check #(
        .WIDTH(WIDTH)
    ) u_shadow_check (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_clear        (r_clear),
        .i_load         (r_load),
        .i_up_down      (r_up_down),
        .i_d            (r_d),
        .i_qd           (i_qd),
        .o_mismatch     (o_mismatch),
        .o_mismatch_cnt (o_mismatch_cnt)
    );
`else
    logic [WIDTH-1:0] w_unused_qd;
    assign w_unused_qd    = i_qd;
    assign o_mismatch     = 1'b0;
    assign o_mismatch_cnt = '0;
`endif

endmodule
